// File: rtl/syn_fetch_queue_if.sv
// syn_fetch_queue_if: fetch-side bus between the prefetch queue, the instruction
// memory and the decode stage.
//   master : the fetch queue (drives im_addr and the head-of-queue outputs)
//   slave  : the core / memory side (drives en, redirect, deq and im_inst)
// Signals: en, redirect, redirect_pc, im_addr, im_inst, deq, valid, inst, pc,
//          pc_4, count, full, and stall_cnt when FQ_STALL_CNT_EN is defined.
interface syn_fetch_queue_if #(
  parameter int unsigned IM_ADDR_BIT = 10,
  parameter int unsigned DEPTH       = 4
);
  logic                       en;
  logic                       redirect;
  logic [IM_ADDR_BIT-1:0]     redirect_pc;
  logic [IM_ADDR_BIT-1:0]     im_addr;
  logic [31:0]                im_inst;
  logic                       deq;
  logic                       valid;
  logic [31:0]                inst;
  logic [IM_ADDR_BIT-1:0]     pc;
  logic [IM_ADDR_BIT-1:0]     pc_4;
  logic [$clog2(DEPTH):0]     count;
  logic                       full;
`ifdef FQ_STALL_CNT_EN
  logic [15:0]                stall_cnt;

  modport master (
    input  en, redirect, redirect_pc, im_inst, deq,
    output im_addr, valid, inst, pc, pc_4, count, full, stall_cnt
  );
  modport slave (
    output en, redirect, redirect_pc, im_inst, deq,
    input  im_addr, valid, inst, pc, pc_4, count, full, stall_cnt
  );
`else
  modport master (
    input  en, redirect, redirect_pc, im_inst, deq,
    output im_addr, valid, inst, pc, pc_4, count, full
  );
  modport slave (
    output en, redirect, redirect_pc, im_inst, deq,
    input  im_addr, valid, inst, pc, pc_4, count, full
  );
`endif
endinterface

// File: rtl/syn_fetch_queue.sv
// syn_fetch_queue: decoupled fetch PC plus a DEPTH-entry prefetch FIFO of
// {instruction, pc}. Each enabled cycle the fetch PC addresses the combinational
// instruction memory and the returned word is enqueued; the oldest entry is
// presented to decode. A redirect flushes the FIFO and reloads the fetch PC.
// Ports:
//   i_clk  clock, rising edge
//   i_rst  asynchronous active-high reset
//   bus    syn_fetch_queue_if.master (memory address, decode head, controls)
// Optional feature: define FQ_STALL_CNT_EN to add bus.stall_cnt, a saturating
// count of cycles spent full with no dequeue, cleared by redirect.
module syn_fetch_queue #(
  parameter int unsigned IM_ADDR_BIT = 10,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned RESET_PC    = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  syn_fetch_queue_if.master bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  typedef logic [IM_ADDR_BIT-1:0] addr_t;
  typedef logic [PtrW-1:0]        ptr_t;
  typedef logic [CntW-1:0]        cnt_t;

  logic [31:0] r_inst_mem [DEPTH];
  addr_t       r_pc_mem   [DEPTH];

  addr_t r_fetch_pc, w_fetch_pc_d;
  ptr_t  r_head, w_head_d;
  ptr_t  r_tail, w_tail_d;
  cnt_t  r_count, w_count_d;

  logic  w_valid, w_full, w_do_deq, w_do_enq;

  always_comb begin
    w_valid      = (r_count != '0);
    w_full       = (r_count == cnt_t'(DEPTH));
    w_do_deq     = 1'b0;
    w_do_enq     = 1'b0;
    w_fetch_pc_d = r_fetch_pc;
    w_head_d     = r_head;
    w_tail_d     = r_tail;
    w_count_d    = r_count;
    if (bus.en) begin
      if (bus.redirect) begin
        // Flush: dropping everything between head and tail is just head <= tail.
        w_count_d    = '0;
        w_head_d     = r_tail;
        w_fetch_pc_d = bus.redirect_pc;
      end else begin
        w_do_deq = bus.deq && w_valid;
        // A dequeue in the same cycle frees the slot, so a full FIFO can still accept.
        w_do_enq = !w_full || w_do_deq;
        if (w_do_enq) begin
          w_tail_d     = r_tail + ptr_t'(1);
          w_fetch_pc_d = r_fetch_pc + addr_t'(1);
        end
        if (w_do_deq) begin
          w_head_d = r_head + ptr_t'(1);
        end
        w_count_d = r_count + cnt_t'(w_do_enq) - cnt_t'(w_do_deq);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fetch_pc <= addr_t'(RESET_PC);
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else begin
      r_fetch_pc <= w_fetch_pc_d;
      r_head     <= w_head_d;
      r_tail     <= w_tail_d;
      r_count    <= w_count_d;
    end
  end

  // Entry storage needs no reset: outputs are gated by valid.
  always_ff @(posedge i_clk) begin
    if (w_do_enq) begin
      r_inst_mem[r_tail] <= bus.im_inst;
      r_pc_mem[r_tail]   <= r_fetch_pc;
    end
  end

  assign bus.im_addr = r_fetch_pc;
  assign bus.valid   = w_valid;
  assign bus.full    = w_full;
  assign bus.count   = r_count;
  assign bus.inst    = w_valid ? r_inst_mem[r_head] : 32'd0;
  assign bus.pc      = w_valid ? r_pc_mem[r_head] : '0;
  assign bus.pc_4    = w_valid ? (r_pc_mem[r_head] + addr_t'(1)) : '0;

`ifdef FQ_STALL_CNT_EN
  logic [15:0] r_stall_cnt, w_stall_cnt_d;

  always_comb begin
    w_stall_cnt_d = r_stall_cnt;
    if (bus.en) begin
      if (bus.redirect) begin
        w_stall_cnt_d = '0;
      end else if (w_full && !bus.deq && (r_stall_cnt != 16'hFFFF)) begin
        w_stall_cnt_d = r_stall_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
    end else begin
      r_stall_cnt <= w_stall_cnt_d;
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_syn_fetch_queue.sv
// tb_syn_fetch_queue: directed scenarios plus randomized traffic for
// syn_fetch_queue, checked every cycle against a queue-based reference model.
// Define FQ_STALL_CNT_EN to also cover the stall counter.
module tb_syn_fetch_queue;
  localparam int unsigned AW       = 10;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned RESET_PC = 0;

  logic clk;
  logic rst;

  syn_fetch_queue_if #(.IM_ADDR_BIT(AW), .DEPTH(DEPTH)) fq_if ();

  syn_fetch_queue #(
    .IM_ADDR_BIT(AW),
    .DEPTH      (DEPTH),
    .RESET_PC   (RESET_PC)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (fq_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: a fixed nonzero hash of the word address.
  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return ({a, 22'h0} ^ (32'(a) * 32'h9E37_79B1)) ^ 32'h1357_0000;
  endfunction

  always_comb fq_if.im_inst = mem_word(fq_if.im_addr);

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: FIFO contents as {inst, pc}, fetch PC, stall counter.
  logic [31+AW:0] mq[$];
  logic [AW-1:0]  m_fpc;
  int unsigned    m_stall;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_fpc   = AW'(RESET_PC);
    m_stall = 0;
  endtask

  task automatic model_edge(input logic en, input logic redir, input logic [AW-1:0] rpc,
                            input logic deq);
    bit is_full, do_deq, do_enq;
    if (!en) return;
    if (redir) begin
      mq.delete();
      m_fpc   = rpc;
      m_stall = 0;
      return;
    end
    is_full = (mq.size() == DEPTH);
    do_deq  = deq && (mq.size() != 0);
    do_enq  = !is_full || do_deq;
    if (is_full && !deq && m_stall < 32'hFFFF) m_stall++;
    if (do_deq) void'(mq.pop_front());
    if (do_enq) begin
      mq.push_back({mem_word(m_fpc), m_fpc});
      m_fpc = m_fpc + AW'(1);
    end
  endtask

  task automatic check_model();
    logic [31+AW:0] h;
    logic [AW-1:0]  p4;
    bit             v;
    v  = (mq.size() != 0);
    h  = v ? mq[0] : '0;
    p4 = v ? h[AW-1:0] + AW'(1) : '0;
    check_eq("valid", 32'(fq_if.valid), 32'(v));
    check_eq("count", 32'(fq_if.count), 32'(mq.size()));
    check_eq("full", 32'(fq_if.full), 32'(mq.size() == DEPTH));
    check_eq("inst", fq_if.inst, h[31+AW:AW]);
    check_eq("pc", 32'(fq_if.pc), 32'(h[AW-1:0]));
    check_eq("pc_4", 32'(fq_if.pc_4), 32'(p4));
    check_eq("im_addr", 32'(fq_if.im_addr), 32'(m_fpc));
`ifdef FQ_STALL_CNT_EN
    check_eq("stall_cnt", 32'(fq_if.stall_cnt), m_stall);
`endif
  endtask

  // Inputs change at the falling edge; outputs are compared at the next falling edge.
  task automatic step(input logic en, input logic redir, input logic [AW-1:0] rpc,
                      input logic deq);
    fq_if.en          = en;
    fq_if.redirect    = redir;
    fq_if.redirect_pc = rpc;
    fq_if.deq         = deq;
    @(posedge clk);
    model_edge(en, redir, rpc, deq);
    @(negedge clk);
    check_model();
  endtask

  initial begin
    fq_if.en          = 1'b0;
    fq_if.redirect    = 1'b0;
    fq_if.redirect_pc = '0;
    fq_if.deq         = 1'b0;
    rst               = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_valid", 32'(fq_if.valid), 32'd0);
    check_eq("rst_count", 32'(fq_if.count), 32'd0);
    check_eq("rst_im_addr", 32'(fq_if.im_addr), RESET_PC);
    rst = 1'b0;
    check_model();

    // Fill: im_addr steps 0..3, then stalls at 4 with head pc 0.
    for (int i = 0; i < 4; i++) begin
      check_eq("fill_im_addr", 32'(fq_if.im_addr), 32'(i));
      step(1'b1, 1'b0, '0, 1'b0);
    end
    check_eq("fill_count", 32'(fq_if.count), 32'd4);
    check_eq("fill_full", 32'(fq_if.full), 32'd1);
    check_eq("fill_im_addr_hold", 32'(fq_if.im_addr), 32'd4);
    check_eq("fill_head_pc", 32'(fq_if.pc), 32'd0);
    check_eq("fill_head_pc_4", 32'(fq_if.pc_4), 32'd1);

`ifdef FQ_STALL_CNT_EN
    repeat (3) step(1'b1, 1'b0, '0, 1'b0);
    check_eq("stall_3", 32'(fq_if.stall_cnt), 32'd3);
`endif

    // Dequeue while full: count stays at DEPTH, head walks 1,2,3.
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 1'b0, '0, 1'b1);
      check_eq("deqfull_pc", 32'(fq_if.pc), 32'(i));
      check_eq("deqfull_count", 32'(fq_if.count), 32'd4);
    end

    // Redirect with a simultaneous deq.
    step(1'b1, 1'b1, 10'h200, 1'b1);
    check_eq("redir_valid", 32'(fq_if.valid), 32'd0);
    check_eq("redir_count", 32'(fq_if.count), 32'd0);
    check_eq("redir_im_addr", 32'(fq_if.im_addr), 32'h200);
`ifdef FQ_STALL_CNT_EN
    check_eq("redir_stall", 32'(fq_if.stall_cnt), 32'd0);
`endif
    step(1'b1, 1'b0, '0, 1'b0);
    check_eq("redir_head_pc", 32'(fq_if.pc), 32'h200);

    // Address wrap at the top of the address space.
    step(1'b1, 1'b1, 10'h3FF, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    check_eq("wrap_pc", 32'(fq_if.pc), 32'h3FF);
    check_eq("wrap_pc_4", 32'(fq_if.pc_4), 32'd0);
    check_eq("wrap_im_addr", 32'(fq_if.im_addr), 32'd0);

    // Disabled: deq and redirect must have no effect.
    repeat (5) step(1'b0, 1'b1, 10'h155, 1'b1);
    check_eq("en0_count", 32'(fq_if.count), 32'd1);

    // Asynchronous reset between edges with three entries queued.
    step(1'b1, 1'b1, 10'h040, 1'b0);
    repeat (3) step(1'b1, 1'b0, '0, 1'b0);
    check_eq("pre_rst_count", 32'(fq_if.count), 32'd3);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_valid", 32'(fq_if.valid), 32'd0);
    check_eq("arst_count", 32'(fq_if.count), 32'd0);
    check_eq("arst_inst", fq_if.inst, 32'd0);
    check_eq("arst_im_addr", 32'(fq_if.im_addr), RESET_PC);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    check_model();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic          r_en, r_redir, r_deq;
      logic [AW-1:0] r_pc;
      r_en    = ($urandom_range(9) != 0);
      r_redir = ($urandom_range(11) == 0);
      r_deq   = ($urandom_range(9) < 5);
      r_pc    = ($urandom_range(3) == 0) ? AW'(10'h3FE + $urandom_range(1)) : AW'($urandom);
      step(r_en, r_redir, r_pc, r_deq);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/syn_fetch_queue.md
# syn_fetch_queue

Parametrised instruction-fetch front end that replaces the single-register PC plus direct instruction-memory path with a decoupled fetch PC and a DEPTH-entry prefetch FIFO. Each enabled cycle it drives a word address to the combinational instruction memory, captures the returned instruction with its PC into the FIFO, and presents the oldest entry to the decode side. Jumps and taken branches flush the FIFO and redirect fetch. It sits between the instruction memory and the decoder/control path of the next-generation core.

## Interface
Parameters:
- IM_ADDR_BIT, 10, width of the word address into instruction memory
- DEPTH, 4, number of FIFO entries; power of two, at least 2
- RESET_PC, 0, word address loaded into the fetch PC on reset

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous, active-high
- en  input  1  global enable; when low, all state holds
- redirect  input  1  jump or taken branch resolved this cycle
- redirect_pc  input  IM_ADDR_BIT  new word address; valid when redirect=1
- im_addr  output  IM_ADDR_BIT  address to instruction memory; equals fetch PC
- im_inst  input  32  instruction at im_addr, same cycle
- deq  input  1  consumer takes the head entry this cycle
- valid  output  1  head entry present (count != 0)
- inst  output  32  head instruction; 32'd0 when valid=0
- pc  output  IM_ADDR_BIT  head word address; 0 when valid=0
- pc_4  output  IM_ADDR_BIT  pc + 1 modulo 2^IM_ADDR_BIT; 0 when valid=0
- count  output  clog2(DEPTH)+1  occupied entries, 0..DEPTH
- full  output  1  count == DEPTH

## Operation
- State: fetch PC, head pointer, tail pointer, count, and DEPTH entries of {inst, pc}.
- All addresses are word addresses. Increments wrap modulo 2^IM_ADDR_BIT; pointers wrap modulo DEPTH.
- Precedence applies to each cycle with en=1:
  - redirect=1: count<=0, head<=tail, fetch PC<=redirect_pc, no enqueue. deq is ignored.
  - otherwise, do_deq = deq && valid; do_enq = !full || do_deq.
  - do_enq: write {im_inst, fetch PC} at tail, advance tail, fetch PC <= fetch PC + 1.
  - do_deq: advance head.
  - count += do_enq - do_deq.
- deq while valid=0 has no effect.
- en=0: nothing changes, including on deq and redirect. Outputs keep reflecting the held state.
- Reset, asynchronous: fetch PC=RESET_PC, pointers=0, count=0. Outputs: valid=0, inst=0, pc=0, pc_4=0, full=0, count=0, im_addr=RESET_PC.
- Reset asserted mid-operation discards all entries immediately.

## Timing
- im_addr is combinational from the fetch PC. im_inst is sampled at the same edge.
- An enqueue into an empty FIFO is visible at the head one cycle later. Latency from reset release to valid=1 is one enabled edge.
- Redirect at edge N: valid=0 after N. The entry for redirect_pc is at the head after edge N+1. Redirect penalty is one cycle.
- Simultaneous enqueue and dequeue while full is allowed; count stays at DEPTH. While full without deq, the fetch PC stalls and im_addr holds.
- inst, pc and pc_4 are combinational from the head entry, gated by valid.

## Configuration
- Macro FQ_STALL_CNT_EN.
- Defined: adds output stall_cnt [15:0]. It resets to 0 and increments on every cycle with en=1, redirect=0, full=1 and deq=0. It saturates at 16'hFFFF and is cleared by redirect.
- Undefined: the port and the counter are absent. All other behaviour is identical.

## Test plan
- Reset, then en=1, deq=0, DEPTH=4, RESET_PC=0 → im_addr steps 0,1,2,3. After 4 edges count=4 and full=1. im_addr holds at 4 and the head shows pc=0, pc_4=1.
- Full FIFO, then deq=1 for 3 cycles → count stays 4 and the head pc goes 1,2,3. Enqueued entries carry pc 4,5,6.
- Redirect with redirect_pc=10'h200 and deq=1 at the same edge → next cycle valid=0, count=0, im_addr=10'h200. One edge later the head pc=10'h200.
- Fetch PC at 10'h3FF, IM_ADDR_BIT=10 → that entry has pc_4=0 and the next im_addr is 0.
- en=0 for 5 cycles with deq=1 and redirect=1 → count, head and im_addr are unchanged.
- rst pulsed asynchronously between edges while count=3 → valid, count and inst go to 0 immediately and im_addr=RESET_PC. With FQ_STALL_CNT_EN defined, 3 full stalled cycles give stall_cnt=3, and stall_cnt=0 after the next redirect.
